// File: rtl/tank_pkg.sv
// Shared types and constants for the tank bullet logic.
// Holds the slot-pool geometry, the owner encoding, and the spawn command
// layout shared by the scheduler and its per-tank shot gates.
package tank_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;
    localparam int ANGLE_MAX = 44;
    localparam int POS_W     = 10;
    localparam int ANGLE_W   = 6;
    localparam int AMMO_W    = 3;

    typedef enum logic {
        TANK1 = 1'b0,
        TANK2 = 1'b1
    } owner_t;

    typedef struct packed {
        logic [SLOT_W-1:0]  slot;
        owner_t             owner;
        logic [POS_W-1:0]   x;
        logic [POS_W-1:0]   y;
        logic [ANGLE_W-1:0] angle;
    } spawn_cmd_t;

endpackage

// File: rtl/shot_gate.sv
// Per-tank shot gate: turns a held shoot level into at most one request per
// press, gated by the tank's cooldown and live-bullet count.
//
// Ports:
//   frame_clk  frame clock
//   Reset      asynchronous active-high reset
//   clear      synchronous clear (round over)
//   shoot      held shoot level from the tank
//   ammo       live bullet count owned by this tank (registered, from top)
//   grant      this tank won a slot this frame
//   req        request is live this frame (new edge or pending, and eligible)
module shot_gate
    import tank_pkg::*;
#(
    parameter int COOLDOWN     = 15,
    parameter int MAX_PER_TANK = 4
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic              clear,
    input  logic              shoot,
    input  logic [AMMO_W-1:0] ammo,
    input  logic              grant,
    output logic              req
);

    localparam int                COOL_W    = $clog2(COOLDOWN + 1);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN);
    localparam logic [COOL_W-1:0] COOL_ONE  = COOL_W'(1);
    localparam logic [AMMO_W-1:0] AMMO_CAP  = AMMO_W'(MAX_PER_TANK);

    logic              shoot_prev;
    logic              pending;
    logic [COOL_W-1:0] cooldown;
    logic              rise;
    logic              eligible;

    assign rise     = shoot & ~shoot_prev;
    assign eligible = (cooldown == '0) && (ammo < AMMO_CAP);
    // A new edge while pending simply merges into the pending request; an
    // ineligible request (new or pending) vanishes rather than waiting.
    assign req      = (rise | pending) & eligible;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            shoot_prev <= 1'b0;
            pending    <= 1'b0;
            cooldown   <= '0;
        end else if (clear) begin
            shoot_prev <= 1'b0;
            pending    <= 1'b0;
            cooldown   <= '0;
        end else begin
            shoot_prev <= shoot;
            // Losing arbitration (or finding no free slot) keeps the request.
            pending    <= req & ~grant;
            if (grant) begin
                cooldown <= COOL_LOAD;
            end else if (cooldown != '0) begin
                cooldown <= cooldown - COOL_ONE;
            end
        end
    end

endmodule

// File: rtl/bullet_scheduler.sv
// Bullet slot scheduler for two tanks.
// Shares a fixed pool of bullet slots between the tanks, grants at most one
// spawn per frame (round-robin on contention), tracks per-slot lifetime and
// per-tank live counts, and retires slots on expiry or hit.
//
// Ports:
//   frame_clk, Reset        frame clock, async active-high reset
//   game_end                nonzero clears all state at the next frame edge
//   shoot1/2                held shoot levels
//   tank1_*/tank2_*         tank position and angle, sampled at grant
//   slot_hit                per-slot collision strobe
//   spawn_*                 registered spawn command to the bullet datapath
//   slot_active/slot_owner  live mask and owner bit per slot
//   ammo1/2                 live bullet count per tank
//
// Spawn handshake: spawn_valid is a one-frame pulse with no ready; the
// datapath must load the bullet in the frame the pulse is present. The
// spawn_* fields are meaningful only while spawn_valid is high and read zero
// otherwise.
module bullet_scheduler
    import tank_pkg::*;
#(
    parameter int MAX_PER_TANK = 4,
    parameter int LIFETIME     = 600,
    parameter int COOLDOWN     = 15
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [1:0]           game_end,
    input  logic                 shoot1,
    input  logic                 shoot2,
    input  logic [POS_W-1:0]     tank1_x,
    input  logic [POS_W-1:0]     tank1_y,
    input  logic [POS_W-1:0]     tank2_x,
    input  logic [POS_W-1:0]     tank2_y,
    input  logic [ANGLE_W-1:0]   tank1_angle,
    input  logic [ANGLE_W-1:0]   tank2_angle,
    input  logic [NUM_SLOTS-1:0] slot_hit,
    output logic                 spawn_valid,
    output logic [SLOT_W-1:0]    spawn_slot,
    output logic                 spawn_owner,
    output logic [POS_W-1:0]     spawn_x,
    output logic [POS_W-1:0]     spawn_y,
    output logic [ANGLE_W-1:0]   spawn_angle,
    output logic [NUM_SLOTS-1:0] slot_active,
    output logic [NUM_SLOTS-1:0] slot_owner,
    output logic [AMMO_W-1:0]    ammo1,
    output logic [AMMO_W-1:0]    ammo2
);

    localparam int                LIFE_W    = $clog2(LIFETIME + 1);
    localparam logic [LIFE_W-1:0] LIFE_LOAD = LIFE_W'(LIFETIME);
    localparam logic [LIFE_W-1:0] LIFE_ONE  = LIFE_W'(1);
    localparam logic [AMMO_W:0]   CNT_ONE   = (AMMO_W+1)'(1);

    logic                 clear;
    logic                 req1;
    logic                 req2;
    logic                 contested;
    logic                 rr;          // 0 favours tank 1 on contention
    owner_t               winner;
    logic                 grant_any;
    logic                 grant1;
    logic                 grant2;
    logic [SLOT_W-1:0]    free_slot;
    logic                 any_free;
    logic [NUM_SLOTS-1:0] retire;
    logic [AMMO_W:0]      ret1;
    logic [AMMO_W:0]      ret2;
    logic [AMMO_W:0]      ammo1_next;
    logic [AMMO_W:0]      ammo2_next;
    logic [LIFE_W-1:0]    life [NUM_SLOTS];
    spawn_cmd_t           cmd;
    spawn_cmd_t           spawn_q;

    assign clear = |game_end;

    shot_gate #(
        .COOLDOWN     (COOLDOWN),
        .MAX_PER_TANK (MAX_PER_TANK)
    ) gate1 (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .clear     (clear),
        .shoot     (shoot1),
        .ammo      (ammo1),
        .grant     (grant1),
        .req       (req1)
    );

    shot_gate #(
        .COOLDOWN     (COOLDOWN),
        .MAX_PER_TANK (MAX_PER_TANK)
    ) gate2 (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .clear     (clear),
        .shoot     (shoot2),
        .ammo      (ammo2),
        .grant     (grant2),
        .req       (req2)
    );

    // Lowest-index free slot from the registered mask, so a slot retired
    // this frame only becomes reusable next frame.
    always_comb begin
        free_slot = '0;
        any_free  = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_active[i]) begin
                free_slot = SLOT_W'(i);
                any_free  = 1'b1;
            end
        end
    end

    always_comb begin
        contested = req1 & req2;
        if (contested) begin
            winner = rr ? TANK2 : TANK1;
        end else if (req2) begin
            winner = TANK2;
        end else begin
            winner = TANK1;
        end
        grant_any = (req1 | req2) & any_free;
        grant1    = grant_any & (winner == TANK1);
        grant2    = grant_any & (winner == TANK2);
    end

    always_comb begin
        cmd.slot  = free_slot;
        cmd.owner = winner;
        cmd.x     = (winner == TANK2) ? tank2_x : tank1_x;
        cmd.y     = (winner == TANK2) ? tank2_y : tank1_y;
        cmd.angle = (winner == TANK2) ? tank2_angle : tank1_angle;
    end

    // A hit coinciding with expiry is still a single retire; hits on idle
    // slots are masked out by slot_active.
    always_comb begin
        retire = '0;
        ret1   = '0;
        ret2   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            retire[i] = slot_active[i] & ((life[i] == LIFE_ONE) | slot_hit[i]);
            if (retire[i]) begin
                if (slot_owner[i]) begin
                    ret2 = ret2 + CNT_ONE;
                end else begin
                    ret1 = ret1 + CNT_ONE;
                end
            end
        end
    end

    // One spare bit catches an underflow so a count clamps at zero
    // instead of wrapping.
    assign ammo1_next = {1'b0, ammo1} + {{AMMO_W{1'b0}}, grant1} - ret1;
    assign ammo2_next = {1'b0, ammo2} + {{AMMO_W{1'b0}}, grant2} - ret2;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            spawn_valid <= 1'b0;
            spawn_q     <= '0;
            rr          <= 1'b0;
            slot_active <= '0;
            slot_owner  <= '0;
            ammo1       <= '0;
            ammo2       <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                life[i] <= '0;
            end
        end else if (clear) begin
            spawn_valid <= 1'b0;
            spawn_q     <= '0;
            rr          <= 1'b0;
            slot_active <= '0;
            slot_owner  <= '0;
            ammo1       <= '0;
            ammo2       <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                life[i] <= '0;
            end
        end else begin
            spawn_valid <= grant_any;
            spawn_q     <= grant_any ? cmd : '0;
            if (grant_any && contested) begin
                rr <= ~rr;
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
                // The granted slot is idle, so it can never also be retiring.
                if (grant_any && (free_slot == SLOT_W'(i))) begin
                    slot_active[i] <= 1'b1;
                    slot_owner[i]  <= (winner == TANK2);
                    life[i]        <= LIFE_LOAD;
                end else if (retire[i]) begin
                    slot_active[i] <= 1'b0;
                    life[i]        <= '0;
                end else if (slot_active[i]) begin
                    life[i] <= life[i] - LIFE_ONE;
                end
            end
            ammo1 <= ammo1_next[AMMO_W] ? '0 : ammo1_next[AMMO_W-1:0];
            ammo2 <= ammo2_next[AMMO_W] ? '0 : ammo2_next[AMMO_W-1:0];
        end
    end

    assign spawn_slot  = spawn_q.slot;
    assign spawn_owner = spawn_q.owner;
    assign spawn_x     = spawn_q.x;
    assign spawn_y     = spawn_q.y;
    assign spawn_angle = spawn_q.angle;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler with a spawn scoreboard.
module tb_bullet_scheduler;
    import tank_pkg::*;

    localparam int LIFETIME = 600;
    localparam int COOLDOWN = 15;
    localparam int CMD_W    = $bits(spawn_cmd_t);

    logic                 frame_clk = 1'b0;
    logic                 Reset;
    logic [1:0]           game_end;
    logic                 shoot1, shoot2;
    logic [POS_W-1:0]     tank1_x, tank1_y, tank2_x, tank2_y;
    logic [ANGLE_W-1:0]   tank1_angle, tank2_angle;
    logic [NUM_SLOTS-1:0] slot_hit;
    logic                 spawn_valid;
    logic [SLOT_W-1:0]    spawn_slot;
    logic                 spawn_owner;
    logic [POS_W-1:0]     spawn_x, spawn_y;
    logic [ANGLE_W-1:0]   spawn_angle;
    logic [NUM_SLOTS-1:0] slot_active, slot_owner;
    logic [AMMO_W-1:0]    ammo1, ammo2;

    int                   checks = 0;
    int                   failures = 0;
    int                   frame = 0;
    logic [CMD_W-1:0]     exp_q[$];
    logic [CMD_W-1:0]     got, want;
    logic                 rr_model;
    logic [NUM_SLOTS-1:0] own_model;
    int                   gframe [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] exp_act, last_exp, last_act;
    int                   e1, e2;

    bullet_scheduler #(
        .MAX_PER_TANK (4),
        .LIFETIME     (LIFETIME),
        .COOLDOWN     (COOLDOWN)
    ) dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .game_end    (game_end),
        .shoot1      (shoot1),
        .shoot2      (shoot2),
        .tank1_x     (tank1_x),
        .tank1_y     (tank1_y),
        .tank2_x     (tank2_x),
        .tank2_y     (tank2_y),
        .tank1_angle (tank1_angle),
        .tank2_angle (tank2_angle),
        .slot_hit    (slot_hit),
        .spawn_valid (spawn_valid),
        .spawn_slot  (spawn_slot),
        .spawn_owner (spawn_owner),
        .spawn_x     (spawn_x),
        .spawn_y     (spawn_y),
        .spawn_angle (spawn_angle),
        .slot_active (slot_active),
        .slot_owner  (slot_owner),
        .ammo1       (ammo1),
        .ammo2       (ammo2)
    );

    // ---------------- clock ----------------
    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver / helper tasks ----------------
    task automatic tick();
        @(posedge frame_clk);
        frame++;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_from(input int slot, input logic owner);
        spawn_cmd_t c;
        c.slot  = SLOT_W'(slot);
        c.owner = owner ? TANK2 : TANK1;
        c.x     = owner ? tank2_x : tank1_x;
        c.y     = owner ? tank2_y : tank1_y;
        c.angle = owner ? tank2_angle : tank1_angle;
        exp_q.push_back(c);
    endtask

    // Both tanks press together from idle: the rr favourite is granted slot s0
    // this frame, the other tank (pending) slot s0+1 the next frame.
    task automatic fire_pair(input int s0);
        logic first, second;
        tank1_x     = 10'($urandom_range(0, 639));
        tank1_y     = 10'($urandom_range(0, 479));
        tank1_angle = 6'($urandom_range(0, ANGLE_MAX));
        tank2_x     = 10'($urandom_range(0, 639));
        tank2_y     = 10'($urandom_range(0, 479));
        tank2_angle = 6'($urandom_range(0, ANGLE_MAX));
        first  = rr_model;
        second = ~rr_model;
        shoot1 = 1'b1;
        shoot2 = 1'b1;
        push_from(s0, first);
        push_from(s0 + 1, second);
        tick();
        gframe[s0] = frame;
        check("pair_first_valid", spawn_valid, 1);
        check("pair_first_owner", spawn_owner, first);
        tick();
        gframe[s0 + 1] = frame;
        check("pair_second_valid", spawn_valid, 1);
        check("pair_second_owner", spawn_owner, second);
        own_model[s0]     = first;
        own_model[s0 + 1] = second;
        rr_model = ~rr_model;
        shoot1 = 1'b0;
        shoot2 = 1'b0;
        repeat (16) tick();
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge frame_clk) begin
        if (!Reset && spawn_valid) begin
            got = {spawn_slot, spawn_owner, spawn_x, spawn_y, spawn_angle};
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL spawn_unexpected observed=%0h expected=none", got);
            end
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checks++;
                assert (got === want) else begin
                    failures++;
                    $error("FAIL spawn_cmd observed=%0h expected=%0h", got, want);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        Reset = 1'b1;
        game_end = 2'b00;
        shoot1 = 1'b0;
        shoot2 = 1'b0;
        tank1_x = '0; tank1_y = '0; tank1_angle = '0;
        tank2_x = '0; tank2_y = '0; tank2_angle = '0;
        slot_hit = '0;
        rr_model = 1'b0;
        own_model = '0;
        repeat (3) tick();
        check("rst_valid", spawn_valid, 0);
        check("rst_active", slot_active, 0);
        check("rst_ammo1", ammo1, 0);
        check("rst_ammo2", ammo2, 0);
        Reset = 1'b0;
        repeat (4) tick();

        // Single press held for 30 frames: exactly one spawn.
        tank1_x = 10'd100; tank1_y = 10'd200; tank1_angle = 6'd11;
        shoot1 = 1'b1;
        push_from(0, 1'b0);
        tick();
        check("t1_valid", spawn_valid, 1);
        check("t1_slot", spawn_slot, 0);
        check("t1_owner", spawn_owner, 0);
        check("t1_x", spawn_x, 100);
        check("t1_y", spawn_y, 200);
        check("t1_angle", spawn_angle, 11);
        check("t1_active", slot_active, 8'h01);
        check("t1_ammo1", ammo1, 1);
        repeat (29) tick();
        check("t1_hold_ammo1", ammo1, 1);
        shoot1 = 1'b0;
        slot_hit = 8'h01;
        tick();
        slot_hit = '0;
        check("t1_hit_ammo1", ammo1, 0);
        check("t1_hit_active", slot_active, 0);

        // Simultaneous presses: round-robin order alternates between pairs.
        repeat (2) tick();
        fire_pair(0);
        fire_pair(2);
        check("t2_ammo1", ammo1, 2);
        check("t2_ammo2", ammo2, 2);
        check("t2_active", slot_active, 8'h0F);
        check("t2_owner", slot_owner & slot_active, 8'h06);
        slot_hit = 8'hFF;   // hits on idle slots 4..7 must be ignored
        tick();
        slot_hit = '0;
        check("t2_hit_ammo1", ammo1, 0);
        check("t2_hit_ammo2", ammo2, 0);
        check("t2_hit_active", slot_active, 0);

        // Ammo cap: presses exactly COOLDOWN+1 frames apart, fifth is dropped.
        repeat (2) tick();
        tank1_x = 10'd50; tank1_y = 10'd60; tank1_angle = 6'(ANGLE_MAX);
        for (int k = 0; k < 5; k++) begin
            shoot1 = 1'b1;
            if (k < 4) push_from(k, 1'b0);
            tick();
            check("t3_valid", spawn_valid, (k < 4));
            check("t3_ammo1", ammo1, (k < 4) ? k + 1 : 4);
            shoot1 = 1'b0;
            repeat (15) tick();
        end
        check("t3_cap_ammo1", ammo1, 4);
        slot_hit = 8'h02;
        tick();
        slot_hit = '0;
        check("t3_hit_ammo1", ammo1, 3);
        check("t3_hit_active", slot_active, 8'h0D);
        tick();
        check("t3_no_pending", spawn_valid, 0);
        shoot1 = 1'b1;
        push_from(1, 1'b0);
        tick();
        check("t3_regrant_valid", spawn_valid, 1);
        check("t3_regrant_slot", spawn_slot, 1);
        check("t3_regrant_ammo1", ammo1, 4);
        shoot1 = 1'b0;

        game_end = 2'b01;
        tick();
        game_end = 2'b00;
        rr_model = 1'b0;
        check("ge1_active", slot_active, 0);
        check("ge1_ammo1", ammo1, 0);

        // Cooldown: a press one frame early is dropped and not remembered.
        tick();
        shoot1 = 1'b1;
        push_from(0, 1'b0);
        tick();
        check("t4_grant", spawn_valid, 1);
        shoot1 = 1'b0;
        repeat (14) tick();
        shoot1 = 1'b1;
        tick();
        check("t4_cool_drop", spawn_valid, 0);
        shoot1 = 1'b0;
        repeat (4) begin
            tick();
            check("t4_no_pending", spawn_valid, 0);
        end
        shoot1 = 1'b1;
        push_from(1, 1'b0);
        tick();
        check("t4_regrant", spawn_valid, 1);
        check("t4_regrant_slot", spawn_slot, 1);
        shoot1 = 1'b0;

        game_end = 2'b11;
        tick();
        game_end = 2'b00;
        rr_model = 1'b0;

        // Fill every slot, then idle: each slot retires LIFETIME frames after
        // its grant; slot 3 also takes a hit on its expiry frame.
        for (int p = 0; p < 4; p++) begin
            fire_pair(2 * p);
        end
        check("t5_full_active", slot_active, 8'hFF);
        check("t5_full_ammo1", ammo1, 4);
        check("t5_full_ammo2", ammo2, 4);
        last_exp = 8'hFF;
        last_act = slot_active;
        while (frame <= gframe[7] + LIFETIME + 1) begin
            slot_hit = ((frame + 1) == gframe[3] + LIFETIME) ? 8'h08 : 8'h00;
            tick();
            e1 = 0;
            e2 = 0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                exp_act[s] = (frame - gframe[s]) < LIFETIME;
                if (exp_act[s]) begin
                    if (own_model[s]) e2++;
                    else e1++;
                end
            end
            if (exp_act != last_exp || slot_active != last_act) begin
                check("t5_active", slot_active, exp_act);
                check("t5_ammo1", ammo1, e1);
                check("t5_ammo2", ammo2, e2);
            end
            last_exp = exp_act;
            last_act = slot_active;
        end
        slot_hit = '0;
        check("t5_idle_active", slot_active, 0);

        // game_end with six live slots and tank 2 pending.
        fire_pair(0);
        fire_pair(2);
        shoot2 = 1'b1;
        push_from(4, 1'b1);
        tick();
        check("t6_solo_owner", spawn_owner, 1);
        shoot2 = 1'b0;
        repeat (16) tick();
        shoot1 = 1'b1;
        shoot2 = 1'b1;
        push_from(5, rr_model);
        tick();
        check("t6_win_owner", spawn_owner, rr_model);
        check("t6_active", slot_active, 8'h3F);
        game_end = 2'b10;
        shoot1 = 1'b0;
        shoot2 = 1'b0;
        tick();
        game_end = 2'b00;
        rr_model = 1'b0;
        check("t6_ge_valid", spawn_valid, 0);
        check("t6_ge_active", slot_active, 0);
        check("t6_ge_ammo1", ammo1, 0);
        check("t6_ge_ammo2", ammo2, 0);
        check("t6_ge_owner", slot_owner, 0);
        repeat (2) begin
            tick();
            check("t6_pending_cleared", spawn_valid, 0);
        end

        // Asynchronous reset in the middle of a frame.
        shoot1 = 1'b1;
        push_from(0, 1'b0);
        tick();
        check("t7_grant", spawn_valid, 1);
        shoot1 = 1'b0;
        @(negedge frame_clk);
        #2;
        Reset = 1'b1;
        #1;
        check("t7_rst_valid", spawn_valid, 0);
        check("t7_rst_active", slot_active, 0);
        check("t7_rst_ammo1", ammo1, 0);
        check("t7_rst_x", spawn_x, 0);
        tick();
        Reset = 1'b0;
        repeat (2) tick();
        check("t7_post_valid", spawn_valid, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
